// File: rtl/handshake_arb.sv
// Round-robin arbiter from CHANNELS valid/ready inputs into a DEPTH-entry first-word-fall-through buffer.
// Define HANDSHAKE_ARB_LOCK_EN to add in_last/out_last and packet-lock arbitration.
//   state      | meaning
//   ARB_FREE   | round-robin among all valid channels, rotating per beat
//   ARB_LOCKED | only lock_chan may transfer until its in_last beat is accepted
module handshake_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
`ifdef HANDSHAKE_ARB_LOCK_EN
    input  logic [CHANNELS-1:0]         in_last,
    output logic                        out_last,
`endif
    output logic [CHANNELS-1:0]         in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(CHANNELS)-1:0] out_chan,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CW-1:0] last_grant;
    logic [CW-1:0] grant_idx;
    logic          grant_found;
    logic [CW:0]   cand;
    logic [CW-1:0] sel_idx;
    logic          sel_valid;
    logic          not_full;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [CW-1:0]    mem_chan [DEPTH];

    // Rotating search starting just after the last accepted channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = {1'b0, last_grant} + (CW+1)'(k);
            if (cand >= (CW+1)'(CHANNELS)) begin
                cand = cand - (CW+1)'(CHANNELS);
            end
            if (!grant_found && in_valid[cand[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CW-1:0];
            end
        end
    end

`ifdef HANDSHAKE_ARB_LOCK_EN
    typedef enum logic {ARB_FREE, ARB_LOCKED} lock_state_t;

    lock_state_t   lock_state;
    lock_state_t   lock_state_nxt;
    logic [CW-1:0] lock_chan;
    logic [CW-1:0] lock_chan_nxt;
    logic          mem_last [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_state <= ARB_FREE;
            lock_chan  <= '0;
        end else begin
            lock_state <= lock_state_nxt;
            lock_chan  <= lock_chan_nxt;
        end
    end

    always_comb begin
        lock_state_nxt = lock_state;
        lock_chan_nxt  = lock_chan;
        case (lock_state)
            ARB_FREE: begin
                if (push && !in_last[sel_idx]) begin
                    lock_state_nxt = ARB_LOCKED;
                    lock_chan_nxt  = sel_idx;
                end
            end
            ARB_LOCKED: begin
                if (push && in_last[lock_chan]) begin
                    lock_state_nxt = ARB_FREE;
                end
            end
            default: lock_state_nxt = ARB_FREE;
        endcase
    end

    assign sel_idx   = (lock_state == ARB_LOCKED) ? lock_chan : grant_idx;
    assign sel_valid = (lock_state == ARB_LOCKED) ? in_valid[lock_chan] : grant_found;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_last[wr_ptr] <= in_last[sel_idx];
        end
    end

    assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;
`else
    assign sel_idx   = grant_idx;
    assign sel_valid = grant_found;
`endif

    // A pop in the same cycle never frees a slot for a push.
    assign not_full = (level != LW'(DEPTH));
    assign push     = sel_valid && not_full && rst;
    assign pop      = out_valid && out_ready;

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            last_grant <= CW'(CHANNELS - 1);
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                last_grant <= sel_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (!push && pop) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data[sel_idx*WIDTH +: WIDTH];
            mem_chan[wr_ptr] <= sel_idx;
        end
    end

    // Storage is not reset; gating by out_valid keeps the head at zero when empty.
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_chan  = out_valid ? mem_chan[rd_ptr] : '0;

endmodule

// File: tb/tb_handshake_arb.sv
// Self-checking bench for handshake_arb: vector table plus queue-based reference model.
// Build with HANDSHAKE_ARB_LOCK_EN defined to also cover packet locking.
module tb_handshake_arb;
    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         out_ready;
    logic [2:0]   level;
`ifdef HANDSHAKE_ARB_LOCK_EN
    logic [3:0]   in_last;
    logic         out_last;
`endif

    handshake_arb #(.WIDTH(32), .CHANNELS(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef HANDSHAKE_ARB_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  chan;
        logic        last;
    } ent_t;

    typedef struct packed {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
        logic [2:0] exp_level;
        logic       exp_ovalid;
        logic [1:0] exp_chan;
    } vec_t;

    ent_t        sb_q[$];
    logic [31:0] pop_data[$];
    int          pop_chan[$];
    logic [31:0] src_data [4];
    logic [3:0]  src_last;
    logic [3:0]  exp_ready;
    int          m_last;
    bit          m_locked;
    int          m_lock_chan;
    int          dut_acc;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_ready(input logic [3:0] v);
        logic [3:0] r;
        int c;
        r = '0;
        if (sb_q.size() >= 4) return r;
        if (m_locked) begin
            if (v[m_lock_chan]) r[m_lock_chan] = 1'b1;
            return r;
        end
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (v[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_flush();
        sb_q.delete();
        m_last   = 3;
        m_locked = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        model_flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Apply inputs half a cycle before the edge and compare against the model.
    task automatic drive(input logic [3:0] v, input logic ordy);
        in_valid  = v;
        out_ready = ordy;
        for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = src_data[c];
`ifdef HANDSHAKE_ARB_LOCK_EN
        in_last = src_last;
`endif
        #1;
        exp_ready = model_ready(v);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("level", 32'(level), 32'(sb_q.size()));
        chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("out_data", out_data, sb_q[0].data);
            chk("out_chan", 32'(out_chan), 32'(sb_q[0].chan));
`ifdef HANDSHAKE_ARB_LOCK_EN
            chk("out_last", 32'(out_last), 32'(sb_q[0].last));
`endif
        end else begin
            chk("out_data_idle", out_data, 32'h0);
            chk("out_chan_idle", 32'(out_chan), 32'h0);
        end
        if ((in_valid & in_ready) != 4'b0) dut_acc++;
    endtask

    task automatic advance();
        logic       do_pop;
        logic [3:0] acc;
        ent_t       e;
        do_pop = (sb_q.size() != 0) && out_ready;
        acc    = exp_ready & in_valid;
        @(posedge clk);
        if (do_pop) begin
            pop_data.push_back(sb_q[0].data);
            pop_chan.push_back(int'(sb_q[0].chan));
            void'(sb_q.pop_front());
        end
        for (int c = 0; c < 4; c++) begin
            if (acc[c]) begin
                e.data = src_data[c];
                e.chan = 2'(c);
                e.last = src_last[c];
                sb_q.push_back(e);
                m_last = c;
`ifdef HANDSHAKE_ARB_LOCK_EN
                if (!m_locked && !src_last[c]) begin
                    m_locked    = 1'b1;
                    m_lock_chan = c;
                end else if (m_locked && src_last[c]) begin
                    m_locked = 1'b0;
                end
`endif
                src_data[c] = src_data[c] + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        dut_acc  = 0;
        in_data  = '0;
        src_last = 4'b1111;
        for (int c = 0; c < 4; c++) src_data[c] = 32'hC000_0000 | (c << 16);

        // Full contention, draining every cycle: strict rotation, level stays at 1.
        vecs[0] = '{4'b1111, 1'b1, 4'b0001, 3'd0, 1'b0, 2'd0};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010, 3'd1, 1'b1, 2'd0};
        vecs[2] = '{4'b1111, 1'b1, 4'b0100, 3'd1, 1'b1, 2'd1};
        vecs[3] = '{4'b1111, 1'b1, 4'b1000, 3'd1, 1'b1, 2'd2};
        vecs[4] = '{4'b1111, 1'b1, 4'b0001, 3'd1, 1'b1, 2'd3};
        vecs[5] = '{4'b1111, 1'b1, 4'b0010, 3'd1, 1'b1, 2'd0};
        vecs[6] = '{4'b1111, 1'b1, 4'b0100, 3'd1, 1'b1, 2'd1};
        vecs[7] = '{4'b1111, 1'b1, 4'b1000, 3'd1, 1'b1, 2'd2};
        vecs[8] = '{4'b0000, 1'b1, 4'b0000, 3'd1, 1'b1, 2'd3};
        vecs[9] = '{4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 2'd0};

        // Values while reset is held.
        rst       = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #13;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_out_data", out_data, 32'h0);

        do_reset();
        pop_chan.delete();
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].ordy);
            chk("vec_ready", 32'(in_ready), 32'(vecs[i].exp_ready));
            chk("vec_level", 32'(level), 32'(vecs[i].exp_level));
            chk("vec_ovalid", 32'(out_valid), 32'(vecs[i].exp_ovalid));
            chk("vec_chan", 32'(out_chan), 32'(vecs[i].exp_chan));
            advance();
        end
        chk("rr_pop_count", 32'(pop_chan.size()), 32'd8);
        for (int i = 0; i < pop_chan.size() && i < 8; i++) chk("rr_order", 32'(pop_chan[i]), 32'(i % 4));

        // Backpressure on channel 2: four accepted, remaining beats wait for space.
        do_reset();
        src_data[2] = 32'hA0;
        dut_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            drive(4'b0100, 1'b0);
            advance();
        end
        chk("full_accepts", 32'(dut_acc), 32'd4);
        drive(4'b0100, 1'b0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'h0);
        advance();
        pop_data.delete();
        for (int i = 0; i < 8; i++) begin
            drive((src_data[2] <= 32'hA5) ? 4'b0100 : 4'b0000, 1'b1);
            advance();
        end
        chk("drain_count", 32'(pop_data.size()), 32'd6);
        for (int i = 0; i < pop_data.size() && i < 6; i++) chk("drain_order", pop_data[i], 32'hA0 + 32'(i));

        // Full buffer with a pop pending: pop only, then push and pop together.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1000, 1'b0);
            advance();
        end
        drive(4'b0010, 1'b1);
        chk("popfull_level", 32'(level), 32'd4);
        chk("popfull_ready", 32'(in_ready), 32'h0);
        advance();
        drive(4'b0010, 1'b1);
        chk("pushpop_level", 32'(level), 32'd3);
        chk("pushpop_ready", 32'(in_ready), 32'b0010);
        advance();
        drive(4'b0000, 1'b0);
        chk("pushpop_hold", 32'(level), 32'd3);
        advance();

        // Mid-stream asynchronous reset, away from any clock edge.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 1'b0);
            advance();
        end
        in_valid  = 4'b1010;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        model_flush();
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_level", 32'(level), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pop_chan.delete();
        drive(4'b1010, 1'b1);
        chk("arst_first_grant", 32'(in_ready), 32'b0010);
        advance();
        drive(4'b0000, 1'b1);
        chk("arst_first_chan", 32'(out_chan), 32'd1);
        advance();

`ifdef HANDSHAKE_ARB_LOCK_EN
        // ch1 holds the grant for a three-beat packet while ch0 and ch2 wait.
        do_reset();
        for (int c = 0; c < 4; c++) src_data[c] = 32'd0;
        src_last = 4'b1111;
        drive(4'b0001, 1'b1);
        advance();
        pop_chan.delete();
        for (int i = 0; i < 8; i++) begin
            src_last[1] = (src_data[1] == 32'd2);
            drive({1'b0, src_data[2] < 32'd1, src_data[1] < 32'd3, src_data[0] < 32'd2}, 1'b1);
            advance();
        end
        src_last = 4'b1111;
        chk("lock_count", 32'(pop_chan.size()), 32'd6);
        begin
            int exp_seq [6];
            exp_seq = '{0, 1, 1, 1, 2, 0};
            for (int i = 0; i < pop_chan.size() && i < 6; i++) chk("lock_order", 32'(pop_chan[i]), 32'(exp_seq[i]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
